// File: rtl/complex_mult_stim_gen.sv
// Operand generator and result checker for the complex multiplier.
// Define CMPLX_STIM_CHECK_EN to compile in the expected-value multiplier and error counters.
module complex_mult_stim_gen #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TRANSACTION_NR = 20,
    parameter logic [31:0] LFSR_SEED      = 32'hACE12B3D,
    parameter int unsigned RDY_GAP        = 0
) (
    input  logic                          clk,
    input  logic                          sw_rst,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic                          op_ready,
    output logic                          op_val,
    output logic [4*DATA_WIDTH-1:0]       op_data,
    input  logic                          res_val,
    output logic                          res_ready,
    input  logic [2*(2*DATA_WIDTH+1)-1:0] res_data,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   txn_cnt,
    output logic [15:0]                   err_cnt,
    output logic                          err_flag
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned RW = 2 * W + 1;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [3:0][31:0] LFSR_INIT = {
        {LFSR_SEED[7:0],  LFSR_SEED[31:8]},
        {LFSR_SEED[15:0], LFSR_SEED[31:16]},
        {LFSR_SEED[23:0], LFSR_SEED[31:24]},
        LFSR_SEED
    };

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RES, S_DONE} state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [4*W-1:0] gen_ops(input logic [1:0] m, input logic [15:0] cnt,
                                               input logic [4*W-1:0] rnd);
        logic [W-1:0]   n;
        logic [4*W-1:0] ops;
        n = W'(cnt);
        case (m)
            2'd0:    ops = {W'(2), W'(3), W'(4), W'(2)};
            2'd1:    ops = rnd;
            2'd2:    ops = '1;
            default: ops = {n, n, ~n, ~n};
        endcase
        return ops;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [4*W-1:0]   op_q, op_d;
    logic [7:0]       gap_q, gap_d;
    logic [15:0]      txn_q, txn_d, txn_inc;
    logic [3:0][31:0] lfsr_q, lfsr_d;
    logic [4*W-1:0]   lfsr_ops;
    logic             start_acc, op_acc, res_acc, last_txn;

    // Both handshakes transfer on a rising edge where valid and ready are high together;
    // op_val is held with stable op_data until op_ready, and res_data is only sampled with res_ready.
    assign start_acc = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign op_acc    = (state_q == S_ISSUE) && op_ready;
    assign res_acc   = (state_q == S_WAIT_RES) && (gap_q == 8'd0) && res_val;
    assign txn_inc   = txn_q + 16'd1;
    assign last_txn  = (txn_inc == 16'(TRANSACTION_NR));
    assign lfsr_ops  = {lfsr_q[0][W-1:0], lfsr_q[1][W-1:0], lfsr_q[2][W-1:0], lfsr_q[3][W-1:0]};

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_ISSUE;
            S_ISSUE:        if (op_ready) state_d = S_WAIT_RES;
            S_WAIT_RES:     if (res_acc) state_d = last_txn ? S_DONE : S_ISSUE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_val    = 1'b0;
        res_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_ISSUE: begin
                op_val = 1'b1;
                busy   = 1'b1;
            end
            S_WAIT_RES: begin
                res_ready = (gap_q == 8'd0);
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // The LFSRs free-run across runs; only sw_rst returns them to their seeds.
    always_comb begin
        mode_d = mode_q;
        op_d   = op_q;
        gap_d  = gap_q;
        txn_d  = txn_q;
        lfsr_d = lfsr_q;
        if (start_acc) begin
            mode_d = mode;
            op_d   = gen_ops(mode, 16'd0, lfsr_ops);
            txn_d  = 16'd0;
        end
        if (op_acc) begin
            gap_d = 8'(RDY_GAP);
            for (int k = 0; k < 4; k++) begin
                lfsr_d[k] = lfsr_step(lfsr_q[k]);
            end
        end else if ((state_q == S_WAIT_RES) && (gap_q != 8'd0)) begin
            gap_d = gap_q - 8'd1;
        end
        if (res_acc) begin
            txn_d = txn_inc;
            if (!last_txn) begin
                op_d = gen_ops(mode_q, txn_inc, lfsr_ops);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            mode_q <= 2'd0;
            op_q   <= '0;
            gap_q  <= 8'd0;
            txn_q  <= 16'd0;
            lfsr_q <= LFSR_INIT;
        end else begin
            mode_q <= mode_d;
            op_q   <= op_d;
            gap_q  <= gap_d;
            txn_q  <= txn_d;
            lfsr_q <= lfsr_d;
        end
    end

    assign op_data = op_q;
    assign txn_cnt = txn_q;

`ifdef CMPLX_STIM_CHECK_EN
    logic [2*RW-1:0] exp_q, exp_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            err_flag_q, err_flag_d;
    logic [RW-1:0]   a, b, c, d;

    assign a = RW'(op_q[4*W-1:3*W]);
    assign b = RW'(op_q[3*W-1:2*W]);
    assign c = RW'(op_q[2*W-1:W]);
    assign d = RW'(op_q[W-1:0]);

    // Real part wraps modulo 2^RW, which is its two's complement encoding.
    always_comb begin
        exp_d      = exp_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        if (op_acc) begin
            exp_d = {a * c - b * d, a * d + b * c};
        end
        if (start_acc) begin
            err_cnt_d  = 16'd0;
            err_flag_d = 1'b0;
        end else if (res_acc && (res_data != exp_q)) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            exp_q      <= '0;
            err_cnt_q  <= 16'd0;
            err_flag_q <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_flag = err_flag_q;
`else
    logic unused_res_data;
    assign unused_res_data = ^res_data;
    assign err_cnt  = 16'd0;
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_complex_mult_stim_gen.sv
// Directed bench for complex_mult_stim_gen: a 20-transaction instance with no ready gap
// and a single-transaction instance with a 3-cycle ready gap.
module tb_complex_mult_stim_gen;

    localparam int          W    = 8;
    localparam int          RW   = 2 * W + 1;
    localparam int          NR   = 20;
    localparam logic [31:0] SEED = 32'hACE12B3D;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic            sw_rst, start, op_ready, res_val;
    logic [1:0]      mode;
    logic            op_val, res_ready, busy, done, err_flag;
    logic [4*W-1:0]  op_data;
    logic [2*RW-1:0] res_data;
    logic [15:0]     txn_cnt, err_cnt;

    logic            g_sw_rst, g_start, g_op_ready, g_res_val;
    logic [1:0]      g_mode;
    logic            g_op_val, g_res_ready, g_busy, g_done, g_err_flag;
    logic [4*W-1:0]  g_op_data;
    logic [2*RW-1:0] g_res_data;
    logic [15:0]     g_txn_cnt, g_err_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_lfsr[4];

    complex_mult_stim_gen #(
        .DATA_WIDTH(W), .TRANSACTION_NR(NR), .LFSR_SEED(SEED), .RDY_GAP(0)
    ) u_dut (
        .clk(clk), .sw_rst(sw_rst), .start(start), .mode(mode),
        .op_ready(op_ready), .op_val(op_val), .op_data(op_data),
        .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .txn_cnt(txn_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    complex_mult_stim_gen #(
        .DATA_WIDTH(W), .TRANSACTION_NR(1), .LFSR_SEED(SEED), .RDY_GAP(3)
    ) u_one (
        .clk(clk), .sw_rst(g_sw_rst), .start(g_start), .mode(g_mode),
        .op_ready(g_op_ready), .op_val(g_op_val), .op_data(g_op_data),
        .res_val(g_res_val), .res_ready(g_res_ready), .res_data(g_res_data),
        .busy(g_busy), .done(g_done), .txn_cnt(g_txn_cnt), .err_cnt(g_err_cnt), .err_flag(g_err_flag)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic model_reseed();
        m_lfsr[0] = SEED;
        m_lfsr[1] = {SEED[23:0], SEED[31:24]};
        m_lfsr[2] = {SEED[15:0], SEED[31:16]};
        m_lfsr[3] = {SEED[7:0],  SEED[31:8]};
    endtask

    function automatic logic [4*W-1:0] exp_ops(input int m, input int i);
        logic [W-1:0]   n;
        logic [4*W-1:0] ops;
        n = W'(i);
        case (m)
            0:       ops = 32'h02030402;
            1:       ops = {m_lfsr[0][W-1:0], m_lfsr[1][W-1:0], m_lfsr[2][W-1:0], m_lfsr[3][W-1:0]};
            2:       ops = 32'hFFFFFFFF;
            default: ops = {n, n, ~n, ~n};
        endcase
        return ops;
    endfunction

    function automatic logic [2*RW-1:0] mk_result(input logic [4*W-1:0] ops, input bit corrupt);
        int a, b, c, d, re, im;
        a  = int'(ops[31:24]);
        b  = int'(ops[23:16]);
        c  = int'(ops[15:8]);
        d  = int'(ops[7:0]);
        re = a * c - b * d;
        im = a * d + b * c;
        if (corrupt) im = im - 1;
        return {RW'(re), RW'(im)};
    endfunction

    // One full run on u_dut; abort_at >= 0 applies sw_rst in WAIT_RES of that transaction.
    task automatic drive_run(input int m, input bit stall, input bit corrupt_first,
                             input bit extra_start, input int abort_at);
        logic [4*W-1:0] exp_op;
        int             exp_err;
        bit             stable;
        @(negedge clk);
        start = 1'b1;
        mode  = m[1:0];
        @(negedge clk);
        start = 1'b0;
        mode  = 2'(m + 1);
        checks++;
        if (op_val !== 1'b1 || busy !== 1'b1 || txn_cnt !== 16'd0 || err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL start_m%0d: op_val=%b busy=%b txn=%0d err=%0d flag=%b, required 1 1 0 0 0",
                     m, op_val, busy, txn_cnt, err_cnt, err_flag);
        end
        for (int i = 0; i < NR; i++) begin
            exp_op = exp_ops(m, i);
            checks++;
            if (op_val !== 1'b1 || op_data !== exp_op) begin
                failures++;
                $display("FAIL op_m%0d_t%0d: op_val=%b op_data=%h, required 1 %h", m, i, op_val, op_data, exp_op);
            end
            if (stall && i == 0) begin
                stable   = 1'b1;
                op_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (op_val !== 1'b1 || op_data !== exp_op) stable = 1'b0;
                end
                checks++;
                if (!stable) begin
                    failures++;
                    $display("FAIL stall_hold: op_val=%b op_data=%h, required 1 %h held", op_val, op_data, exp_op);
                end
                op_ready = 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) m_lfsr[k] = lfsr_next(m_lfsr[k]);
            checks++;
            if (op_val !== 1'b0 || res_ready !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL accept_m%0d_t%0d: op_val=%b res_ready=%b busy=%b, required 0 1 1",
                         m, i, op_val, res_ready, busy);
            end
            if (i == abort_at) begin
                sw_rst = 1'b1;
                @(negedge clk);
                sw_rst = 1'b0;
                model_reseed();
                checks++;
                if (op_val !== 1'b0 || op_data !== '0 || res_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                    txn_cnt !== 16'd0 || err_cnt !== 16'd0 || err_flag !== 1'b0) begin
                    failures++;
                    $display("FAIL sw_rst_mid: op_val=%b op_data=%h rdy=%b busy=%b done=%b txn=%0d err=%0d flag=%b, required all 0",
                             op_val, op_data, res_ready, busy, done, txn_cnt, err_cnt, err_flag);
                end
                return;
            end
            res_data = mk_result(exp_op, corrupt_first && i == 0);
            res_val  = 1'b1;
            if (extra_start && i == 5) start = 1'b1;
            @(negedge clk);
            res_val  = 1'b0;
            start    = 1'b0;
            res_data = '0;
            checks++;
            if (txn_cnt !== 16'(i + 1)) begin
                failures++;
                $display("FAIL txn_m%0d_t%0d: txn_cnt=%0d, required %0d", m, i, txn_cnt, i + 1);
            end
            checks++;
            if (i < NR - 1) begin
                if (op_val !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL next_m%0d_t%0d: op_val=%b busy=%b done=%b, required 1 1 0", m, i, op_val, busy, done);
                end
            end else begin
                if (op_val !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                    failures++;
                    $display("FAIL done_m%0d: op_val=%b busy=%b done=%b, required 0 0 1", m, op_val, busy, done);
                end
            end
        end
`ifdef CMPLX_STIM_CHECK_EN
        exp_err = corrupt_first ? 1 : 0;
`else
        exp_err = 0;
`endif
        checks++;
        if (err_cnt !== 16'(exp_err) || err_flag !== (exp_err != 0)) begin
            failures++;
            $display("FAIL err_m%0d: err_cnt=%0d err_flag=%b, required %0d %b", m, err_cnt, err_flag, exp_err, exp_err != 0);
        end
    endtask

    task automatic test_reset();
        sw_rst = 1'b1;
        g_sw_rst = 1'b1;
        repeat (3) @(negedge clk);
        sw_rst = 1'b0;
        g_sw_rst = 1'b0;
        model_reseed();
        @(negedge clk);
        checks++;
        if (op_val !== 1'b0 || op_data !== '0 || res_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            txn_cnt !== 16'd0 || err_cnt !== 16'd0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut: op_val=%b op_data=%h rdy=%b busy=%b done=%b txn=%0d err=%0d flag=%b, required all 0",
                     op_val, op_data, res_ready, busy, done, txn_cnt, err_cnt, err_flag);
        end
        checks++;
        if (g_op_val !== 1'b0 || g_op_data !== '0 || g_res_ready !== 1'b0 || g_busy !== 1'b0 || g_done !== 1'b0 ||
            g_txn_cnt !== 16'd0 || g_err_cnt !== 16'd0 || g_err_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_one: op_val=%b op_data=%h rdy=%b busy=%b done=%b txn=%0d, required all 0",
                     g_op_val, g_op_data, g_res_ready, g_busy, g_done, g_txn_cnt);
        end
    endtask

    task automatic test_single_gap();
        int cyc;
        @(negedge clk);
        g_start = 1'b1;
        g_mode  = 2'd0;
        @(negedge clk);
        g_start = 1'b0;
        g_mode  = 2'd2;
        checks++;
        if (g_op_val !== 1'b1 || g_busy !== 1'b1 || g_op_data !== 32'h02030402) begin
            failures++;
            $display("FAIL gap_issue: op_val=%b busy=%b op_data=%h, required 1 1 02030402", g_op_val, g_busy, g_op_data);
        end
        @(negedge clk);
        checks++;
        if (g_op_val !== 1'b0 || g_res_ready !== 1'b0) begin
            failures++;
            $display("FAIL gap_accept: op_val=%b res_ready=%b, required 0 0", g_op_val, g_res_ready);
        end
        g_res_val  = 1'b1;
        g_res_data = {17'd2, 17'd16};
        cyc = 1;
        while (g_res_ready !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL gap_rise: res_ready rose at cycle %0d after acceptance, required 4", cyc);
        end
        @(negedge clk);
        g_res_val  = 1'b0;
        g_res_data = '0;
        checks++;
        if (g_done !== 1'b1 || g_busy !== 1'b0 || g_txn_cnt !== 16'd1 || g_err_cnt !== 16'd0 ||
            g_err_flag !== 1'b0 || g_op_val !== 1'b0) begin
            failures++;
            $display("FAIL gap_done: done=%b busy=%b txn=%0d err=%0d flag=%b op_val=%b, required 1 0 1 0 0 0",
                     g_done, g_busy, g_txn_cnt, g_err_cnt, g_err_flag, g_op_val);
        end
        g_res_val = 1'b1;
        repeat (3) @(negedge clk);
        g_res_val = 1'b0;
        checks++;
        if (g_txn_cnt !== 16'd1 || g_res_ready !== 1'b0 || g_done !== 1'b1) begin
            failures++;
            $display("FAIL gap_hold: txn=%0d res_ready=%b done=%b, required 1 0 1", g_txn_cnt, g_res_ready, g_done);
        end
    endtask

    task automatic test_mode0_stall();
        drive_run(0, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_corner_error();
        drive_run(2, 1'b0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_sw_rst_mid();
        drive_run(0, 1'b0, 1'b0, 1'b0, 3);
        drive_run(3, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        drive_run(1, 1'b0, 1'b0, 1'b1, -1);
    endtask

    initial begin
        sw_rst = 1'b1; start = 1'b0; mode = 2'd0; op_ready = 1'b1; res_val = 1'b0; res_data = '0;
        g_sw_rst = 1'b1; g_start = 1'b0; g_mode = 2'd0; g_op_ready = 1'b1; g_res_val = 1'b0; g_res_data = '0;
        model_reseed();
        test_reset();
        test_single_gap();
        test_mode0_stall();
        test_corner_error();
        test_sw_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
